// File: rtl/mcm_pipe.sv
// rtl/mcm_pipe.sv - two-stage valid/ready multiple-constant-multiplier bank
//
// Each beat carries LANES unsigned samples and a 2-bit coefficient-set select.
// The block returns four signed products per lane, built from shifts and adds.
//   Stage 1 registers the partial terms x, 2x, 4x, 8x, 32x and 64x.
//   Stage 2 registers the combined, width-reduced products.
//
// Optional build macro: MCM_PIPE_SAT_EN
//   defined   : products are clamped to the signed OUT_W range
//   undefined : products wrap modulo 2^OUT_W
//
// Ports:
//   clk        clock; all logic on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   in_x       LANES samples; lane i at [i*IN_W +: IN_W]
//   in_sel     coefficient set for the beat
//   out_valid  output beat valid
//   out_ready  downstream accepts the output this cycle
//   out_y      products; lane i, tap k at [(i*4+k)*OUT_W +: OUT_W]
//   out_sel    in_sel carried with the beat
module mcm_pipe #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16,
   parameter int LANES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*IN_W-1:0]    in_x,
   input  logic [1:0]               in_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*4*OUT_W-1:0] out_y,
   output logic [1:0]               out_sel
);

   // Width of a registered partial term: 64x needs IN_W+6 bits.
   localparam int TW = IN_W + 6;
   // The working width holds every exact product, including sign.
   // It is never narrower than OUT_W+1. Wrapping is unaffected by the extra bits.
   // Saturation compares the true value, not one that has already wrapped.
   localparam int AW = (OUT_W + 1 > IN_W + 8) ? OUT_W + 1 : IN_W + 8;
   localparam int PW = 4 * OUT_W;

`ifdef MCM_PIPE_SAT_EN
   localparam logic [AW-1:0] SAT_MAX = (AW'(1) << (OUT_W - 1)) - AW'(1);
   localparam logic [AW-1:0] SAT_MIN = -(AW'(1) << (OUT_W - 1));
`endif

   logic                s1_valid;
   logic [1:0]          s1_sel;
   logic [TW-1:0]       s1_t1  [LANES];
   logic [TW-1:0]       s1_t2  [LANES];
   logic [TW-1:0]       s1_t4  [LANES];
   logic [TW-1:0]       s1_t8  [LANES];
   logic [TW-1:0]       s1_t32 [LANES];
   logic [TW-1:0]       s1_t64 [LANES];

   logic                s2_valid;
   logic [1:0]          s2_sel;
   logic [LANES*PW-1:0] s2_y;
   logic [LANES*PW-1:0] prod;

   logic                s2_load;

   function automatic logic [AW-1:0] zx(input logic [TW-1:0] t);
      return {{(AW-TW){1'b0}}, t};
   endfunction

   // Reduce an AW-bit two's-complement value to OUT_W bits.
   function automatic logic [OUT_W-1:0] reduce(input logic [AW-1:0] v);
`ifdef MCM_PIPE_SAT_EN
      if ($signed(v) > $signed(SAT_MAX)) begin
         return SAT_MAX[OUT_W-1:0];
      end else if ($signed(v) < $signed(SAT_MIN)) begin
         return SAT_MIN[OUT_W-1:0];
      end else begin
         return v[OUT_W-1:0];
      end
`else
      return v[OUT_W-1:0];
`endif
   endfunction

   // Return the four taps of one lane, packed with tap0 in the low bits.
   function automatic logic [PW-1:0] lane_prod(
      input logic [TW-1:0] t1,
      input logic [TW-1:0] t2,
      input logic [TW-1:0] t4,
      input logic [TW-1:0] t8,
      input logic [TW-1:0] t32,
      input logic [TW-1:0] t64,
      input logic [1:0]    sel
   );
      logic [AW-1:0] x1, x2, x4, x8, x32, x64;
      logic [AW-1:0] p3, p11, p36;
      logic [AW-1:0] tap0, tap1, tap2, tap3;
      x1  = zx(t1);
      x2  = zx(t2);
      x4  = zx(t4);
      x8  = zx(t8);
      x32 = zx(t32);
      x64 = zx(t64);
      p3  = x4 - x1;
      p11 = x8 + p3;
      p36 = x32 + x4;
      case (sel)
         2'd0: begin
            tap0 = -x2;
            tap1 = -p3;
            tap2 = p3;
            tap3 = p11;
         end
         2'd1: begin
            tap0 = '0;
            tap1 = x64;
            tap2 = '0;
            tap3 = '0;
         end
         2'd2: begin
            tap0 = -x4;
            tap1 = p36;
            tap2 = p36;
            tap3 = -x4;
         end
         default: begin
            tap0 = -x2;
            tap1 = -p3;
            tap2 = p11;
            tap3 = p3;
         end
      endcase
      return {reduce(tap3), reduce(tap2), reduce(tap1), reduce(tap0)};
   endfunction

   // Stage 2 can take new contents when it is empty or is being drained.
   // Stage 1 can take new contents when it is empty or moves into stage 2.
   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_load;
   assign out_valid = s2_valid;
   assign out_y     = s2_y;
   assign out_sel   = s2_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sel   <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_t1[i]  <= '0;
            s1_t2[i]  <= '0;
            s1_t4[i]  <= '0;
            s1_t8[i]  <= '0;
            s1_t32[i] <= '0;
            s1_t64[i] <= '0;
         end
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sel <= in_sel;
            for (int i = 0; i < LANES; i++) begin
               s1_t1[i]  <= TW'(in_x[i*IN_W +: IN_W]);
               s1_t2[i]  <= TW'(in_x[i*IN_W +: IN_W]) << 1;
               s1_t4[i]  <= TW'(in_x[i*IN_W +: IN_W]) << 2;
               s1_t8[i]  <= TW'(in_x[i*IN_W +: IN_W]) << 3;
               s1_t32[i] <= TW'(in_x[i*IN_W +: IN_W]) << 5;
               s1_t64[i] <= TW'(in_x[i*IN_W +: IN_W]) << 6;
            end
         end
      end
   end

   always_comb begin
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         prod[i*PW +: PW] = lane_prod(s1_t1[i], s1_t2[i], s1_t4[i], s1_t8[i],
                                      s1_t32[i], s1_t64[i], s1_sel);
      end
   end

   // Data registers load only with a real beat.
   // A draining stage therefore keeps out_y and out_sel unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sel   <= '0;
         s2_y     <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_y   <= prod;
            s2_sel <= s1_sel;
         end
      end
   end

endmodule

// File: tb/tb_mcm_pipe.sv
// tb/tb_mcm_pipe.sv - directed and randomized self-checking bench for mcm_pipe
module tb_mcm_pipe;

   localparam int NB = 400;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_x;
   logic [1:0]   in_sel;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_y;
   logic [1:0]   out_sel;

   logic         w_in_valid;
   logic         w_in_ready;
   logic [7:0]   w_in_x;
   logic [1:0]   w_in_sel;
   logic         w_out_valid;
   logic         w_out_ready;
   logic [47:0]  w_out_y;
   logic [1:0]   w_out_sel;
   logic [11:0]  w12_exp;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mcm_pipe #(.IN_W(8), .OUT_W(16), .LANES(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sel(out_sel)
   );

   mcm_pipe #(.IN_W(8), .OUT_W(12), .LANES(1)) dut_w12 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_x(w_in_x), .in_sel(w_in_sel),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_y(w_out_y), .out_sel(w_out_sel)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // The same tap0..tap3 values, replicated across all four lanes.
   function automatic logic [255:0] mk4(input int a, input int b, input int c, input int d);
      logic [63:0] l;
      l = {16'(d), 16'(c), 16'(b), 16'(a)};
      return {l, l, l, l};
   endfunction

   function automatic logic [255:0] ref_bus(input logic [31:0] xb, input logic [1:0] s);
      int c [4];
      int p;
      logic [255:0] r;
      r = '0;
      case (s)
         2'd0:    c = '{-2, -3, 3, 11};
         2'd1:    c = '{0, 64, 0, 0};
         2'd2:    c = '{-4, 36, 36, -4};
         default: c = '{-2, -3, 11, 3};
      endcase
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            p = c[k] * int'(xb[i*8 +: 8]);
            r[(i*4+k)*16 +: 16] = p[15:0];
         end
      end
      return r;
   endfunction

   initial begin
      logic [257:0] q [$];
      logic [257:0] e;
      int n_sent;
      int n_got;
      int cyc;

`ifdef MCM_PIPE_SAT_EN
      w12_exp = 12'h7FF;
`else
      w12_exp = 12'hFC0;
`endif

      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_sel = '0; out_ready = 1'b1;
      w_in_valid = 1'b0; w_in_x = '0; w_in_sel = '0; w_out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_y", out_y, 0);
      check("rst_out_sel", out_sel, 0);

      // x=0x10, set 0: two cycles of latency.
      in_x = {4{8'h10}}; in_sel = 2'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat1_not_valid", out_valid, 0);
      tick();
      check("lat2_valid", out_valid, 1);
      check("lat2_y", out_y, mk4(-32, -48, 48, 176));
      check("lat2_sel", out_sel, 0);
      tick();
      check("lat_drained", out_valid, 0);

      // Back-to-back beats with x=255 and sets 1, 2, 3.
      in_x = {4{8'hFF}}; in_sel = 2'd1; in_valid = 1'b1;
      tick();
      in_sel = 2'd2;
      tick();
      check("b2b_set1_y", out_y, mk4(0, 16320, 0, 0));
      check("b2b_set1_sel", out_sel, 1);
      in_sel = 2'd3;
      tick();
      check("b2b_set2_y", out_y, mk4(-1020, 9180, 9180, -1020));
      check("b2b_set2_sel", out_sel, 2);
      in_valid = 1'b0;
      tick();
      check("b2b_set3_y", out_y, mk4(-510, -765, 2805, 765));
      check("b2b_set3_sel", out_sel, 3);
      tick();
      check("b2b_drained", out_valid, 0);

      // Stall: A and B fill the pipe. C waits, then enters as A leaves.
      out_ready = 1'b0; in_valid = 1'b1; in_x = {4{8'd1}}; in_sel = 2'd0;
      tick();
      check("stall_ready_after_one", in_ready, 1);
      in_x = {4{8'd2}}; in_sel = 2'd2;
      tick();
      in_x = {4{8'd3}}; in_sel = 2'd3;
      for (int c = 0; c < 3; c++) begin
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_y", out_y, mk4(-2, -3, 3, 11));
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
      check("release_b_y", out_y, mk4(-8, 72, 72, -8));
      check("release_b_sel", out_sel, 2);
      in_valid = 1'b0;
      tick();
      check("release_c_y", out_y, mk4(-6, -9, 33, 9));
      check("release_c_sel", out_sel, 3);
      tick();
      check("release_no_dup", out_valid, 0);

      // Reset while full and stalled; the beat offered alongside rst is dropped.
      out_ready = 1'b0; in_valid = 1'b1; in_x = {4{8'd5}}; in_sel = 2'd1;
      tick();
      tick();
      check("full_in_ready", in_ready, 0);
      in_x = {4{8'd6}};
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("rstmid_out_valid", out_valid, 0);
      check("rstmid_in_ready", in_ready, 1);
      check("rstmid_out_y", out_y, 0);
      check("rstmid_out_sel", out_sel, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rstmid_no_stale", out_valid, 0);
      end

      // 12-bit instance: 64*255 overflows OUT_W.
      w_in_x = 8'hFF; w_in_sel = 2'd1; w_in_valid = 1'b1;
      tick();
      w_in_valid = 1'b0;
      tick();
      check("w12_valid", w_out_valid, 1);
      check("w12_tap1", w_out_y[23:12], w12_exp);
      check("w12_tap0", w_out_y[11:0], 0);

      // Random handshake traffic against a multiply-based model.
      n_sent = 0; n_got = 0; cyc = 0;
      while (n_got < NB && cyc < 20000) begin
         in_valid  = (n_sent < NB) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_x      = $urandom;
         in_sel    = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            check("rand_pending", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("rand_y", out_y, e[255:0]);
               check("rand_sel", out_sel, e[257:256]);
            end
            n_got++;
         end
         if (in_valid && in_ready) begin
            q.push_back({in_sel, ref_bus(in_x, in_sel)});
            n_sent++;
         end
         tick();
         cyc++;
      end
      check("rand_all_beats", n_got, NB);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
